zbt_port_ctrl: RTL and testbench



---
 rtl/zbt_pkg.sv | 16 +
 rtl/zbt_op_pipe.sv | 43 ++++
 rtl/zbt_port_ctrl.sv | 152 +++++++++++++++
 tb/tb_zbt_port_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zbt_pkg.sv
// Shared defaults and types for the ZBT SRAM port controller.
package zbt_pkg;

  localparam int ZBT_ADDR_W  = 19;
  localparam int ZBT_DATA_W  = 36;
  // Edges from request accept to rd_valid.
  localparam int ZBT_LATENCY = 3;

  // ST_ prefix keeps the literals clear of the SETTLE parameter name.
  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_SETTLE    = 2'd1,
    ST_RUN       = 2'd2
  } zbt_state_e;

endpackage

// File: rtl/zbt_op_pipe.sv
// Two-stage op shift register bridging the accept edge to the point where
// write data must hit the bus and read data must be captured.
module zbt_op_pipe
  import zbt_pkg::*;
#(
  parameter int DATA_W = ZBT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vld_p0,
  input  logic              we_p0,
  input  logic [DATA_W-1:0] wdata_p0,
  output logic              vld_p2,
  output logic              we_p2,
  output logic [DATA_W-1:0] wdata_p2
);

  logic              vld_p1;
  logic              we_p1;
  logic [DATA_W-1:0] wdata_p1;

  // Stage p0 -> p1 -> p2: op qualifiers, cleared by reset so no stale op survives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      we_p1  <= 1'b0;
      vld_p2 <= 1'b0;
      we_p2  <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      we_p1  <= we_p0;
      vld_p2 <= vld_p1;
      we_p2  <= we_p1;
    end
  end

  // Stage p0 -> p1 -> p2: write data rides along; only used when qualified by vld/we
  always_ff @(posedge clk) begin
    wdata_p1 <= wdata_p0;
    wdata_p2 <= wdata_p1;
  end

endmodule

// File: rtl/zbt_port_ctrl.sv
// Request-side controller for one ZBT SRAM: lock/settle gating, registered
// pin drive, two-cycle write-data offset and fixed-latency read return.
module zbt_port_ctrl
  import zbt_pkg::*;
#(
  parameter int ADDR_W = ZBT_ADDR_W,
  parameter int DATA_W = ZBT_DATA_W,
  parameter int SETTLE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_locked,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              ram_cen_b,
  output logic              ram_we_b,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_out,
  output logic              ram_data_oe,
  input  logic [DATA_W-1:0] ram_data_in
);

  localparam int               CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  zbt_state_e        state;
  zbt_state_e        state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              ready_next;

  logic              acc_p0;
  logic              vld_p2;
  logic              we_p2;
  logic [DATA_W-1:0] wdata_p2;
  logic              rd_pend_p3;

  assign acc_p0 = req_valid && req_ready;

  // FSM state and settle counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_WAIT_LOCK;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state: the lock-sampling edge counts as the first settle cycle
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_WAIT_LOCK: begin
        cnt_next = '0;
        if (clk_locked) begin
          if (SETTLE <= 1) begin
            state_next = ST_RUN;
          end else begin
            state_next = ST_SETTLE;
            cnt_next   = CNT_W'(1);
          end
        end
      end
      ST_SETTLE: begin
        if (!clk_locked) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!clk_locked) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_WAIT_LOCK;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode: ready drops on the first edge that sees lock low
  always_comb begin
    ready_next = (state == ST_RUN) && clk_locked;
  end

  // Stage p0 -> p1: handshake result drives the registered control/address pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready   <= 1'b0;
      ram_cen_b   <= 1'b1;
      ram_we_b    <= 1'b1;
      ram_address <= '0;
    end else begin
      req_ready <= ready_next;
      ram_cen_b <= !acc_p0;
      ram_we_b  <= !(acc_p0 && req_we);
      if (acc_p0) begin
        ram_address <= req_addr;
      end
    end
  end

  zbt_op_pipe #(
    .DATA_W (DATA_W)
  ) u_op_pipe (
    .clk      (clk),
    .reset    (reset),
    .vld_p0   (acc_p0),
    .we_p0    (req_we),
    .wdata_p0 (req_wdata),
    .vld_p2   (vld_p2),
    .we_p2    (we_p2),
    .wdata_p2 (wdata_p2)
  );

  // Stage p2 -> p3 (write data on bus) and p3 -> p4 (read data captured)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_data_oe  <= 1'b0;
      ram_data_out <= '0;
      rd_pend_p3   <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
    end else begin
      ram_data_oe <= vld_p2 && we_p2;
      if (vld_p2 && we_p2) begin
        ram_data_out <= wdata_p2;
      end
      rd_pend_p3 <= vld_p2 && !we_p2;
      rd_valid   <= rd_pend_p3;
      if (rd_pend_p3) begin
        rd_data <= ram_data_in;
      end
    end
  end

endmodule

// File: tb/tb_zbt_port_ctrl.sv
// Scoreboard bench for zbt_port_ctrl with a pipelined ZBT SRAM model.
module tb_zbt_port_ctrl;
  import zbt_pkg::*;

  localparam int AW = 19;
  localparam int DW = 36;
  localparam int ST = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_locked;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          ram_cen_b;
  logic          ram_we_b;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_out;
  logic          ram_data_oe;
  logic [DW-1:0] ram_data_in = '0;

  always #5 clk = ~clk;

  zbt_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SETTLE(ST)) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_locked   (clk_locked),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .ram_cen_b    (ram_cen_b),
    .ram_we_b     (ram_we_b),
    .ram_address  (ram_address),
    .ram_data_out (ram_data_out),
    .ram_data_oe  (ram_data_oe),
    .ram_data_in  (ram_data_in)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {a[16:0], a};
  endfunction

  // ---------------- SRAM model (pipelined ZBT, 64 words) ----------------
  logic [DW-1:0] sram [64];
  logic [63:0]   sram_ok = '0;
  logic          s1_v = 1'b0, s1_we = 1'b0, s2_v = 1'b0, s2_we = 1'b0;
  logic [AW-1:0] s1_a = '0, s2_a = '0;
  logic          sram_drv = 1'b0;
  logic [DW-1:0] fwd;

  always_comb begin
    fwd = sram_ok[s1_a[5:0]] ? sram[s1_a[5:0]] : init_word(s1_a);
    if (s2_v && s2_we && (s2_a == s1_a)) fwd = ram_data_out;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      sram_drv <= 1'b0;
    end else begin
      if (s2_v && s2_we) begin
        sram[s2_a[5:0]]    <= ram_data_out;
        sram_ok[s2_a[5:0]] <= 1'b1;
      end
      sram_drv <= s1_v && !s1_we;
      if (s1_v && !s1_we) ram_data_in <= fwd;
      s2_v  <= s1_v;
      s2_we <= s1_we;
      s2_a  <= s1_a;
      s1_v  <= !ram_cen_b;
      s1_we <= !ram_we_b;
      s1_a  <= ram_address;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    int unsigned   due;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          cmd_q[$];
  exp_t          wr_q[$];
  exp_t          rd_q[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_rd = '0;

  task automatic push_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int unsigned k);
    logic [DW-1:0] rv;
    cmd_q.push_back('{due: k, we: we, addr: a, data: d});
    if (we) begin
      ref_mem[a] = d;
      wr_q.push_back('{due: k + 2, we: 1'b1, addr: a, data: d});
    end else begin
      rv = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
      rd_q.push_back('{due: k + ZBT_LATENCY, we: 1'b0, addr: a, data: rv});
    end
  endtask

  // Monitor: every cycle, compare the DUT pins with what is due this cycle
  always @(negedge clk) begin : monitor
    exp_t e;
    while (cmd_q.size() > 0 && cmd_q[0].due < cyc) begin
      chk("cmd_missed", 64'(cmd_q[0].due), 64'(cyc));
      void'(cmd_q.pop_front());
    end
    while (wr_q.size() > 0 && wr_q[0].due < cyc) begin
      chk("wr_missed", 64'(wr_q[0].due), 64'(cyc));
      void'(wr_q.pop_front());
    end
    while (rd_q.size() > 0 && rd_q[0].due < cyc) begin
      chk("rd_missed", 64'(rd_q[0].due), 64'(cyc));
      void'(rd_q.pop_front());
    end
    if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
      e = cmd_q.pop_front();
      chk("cen_b", 64'(ram_cen_b), 64'(0));
      chk("we_b", 64'(ram_we_b), 64'(!e.we));
      chk("address", 64'(ram_address), 64'(e.addr));
      last_addr = e.addr;
    end else begin
      chk("idle_cen_b", 64'(ram_cen_b), 64'(1));
      chk("idle_we_b", 64'(ram_we_b), 64'(1));
      chk("addr_hold", 64'(ram_address), 64'(last_addr));
    end
    if (wr_q.size() > 0 && wr_q[0].due == cyc) begin
      e = wr_q.pop_front();
      chk("data_oe", 64'(ram_data_oe), 64'(1));
      chk("data_out", 64'(ram_data_out), 64'(e.data));
    end else begin
      chk("idle_oe", 64'(ram_data_oe), 64'(0));
    end
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      e = rd_q.pop_front();
      chk("rd_valid", 64'(rd_valid), 64'(1));
      chk("rd_data", 64'(rd_data), 64'(e.data));
      last_rd = e.data;
    end else begin
      chk("idle_rd_valid", 64'(rd_valid), 64'(0));
      chk("rd_data_hold", 64'(rd_data), 64'(last_rd));
    end
    if (sram_drv) chk("bus_overlap", 64'(ram_data_oe), 64'(0));
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit drop_lock, output int unsigned k_acc);
    logic        samp;
    int unsigned n0;
    k_acc = 0;
    @(negedge clk);
    if (drop_lock) clk_locked = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    for (int t = 0; t < 100; t++) begin
      samp = req_ready;
      n0   = cyc;
      @(posedge clk);
      if (samp) begin
        k_acc = n0 + 1;
        push_op(we, a, d, k_acc);
        return;
      end
      @(negedge clk);
    end
    chk("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Call at a negedge where clk_locked is (or has just become) high with the FSM in WAIT_LOCK
  task automatic check_settle(input string tag);
    for (int i = 1; i <= ST; i++) begin
      @(negedge clk);
      chk({tag, "_ready_low"}, 64'(req_ready), 64'(0));
    end
    @(negedge clk);
    chk({tag, "_ready_high"}, 64'(req_ready), 64'(1));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_rd_valid"}, 64'(rd_valid), 64'(0));
    chk({tag, "_rd_data"}, 64'(rd_data), 64'(0));
    chk({tag, "_cen_b"}, 64'(ram_cen_b), 64'(1));
    chk({tag, "_we_b"}, 64'(ram_we_b), 64'(1));
    chk({tag, "_address"}, 64'(ram_address), 64'(0));
    chk({tag, "_data_out"}, 64'(ram_data_out), 64'(0));
    chk({tag, "_data_oe"}, 64'(ram_data_oe), 64'(0));
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int unsigned k, k0, k2, k3, r0;

  initial begin
    reset      = 1'b1;
    clk_locked = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    k3         = 0;
    r0         = 0;

    // Power-on reset and settle
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;
    check_settle("startup");

    // Single write
    send(1'b1, 19'h00012, 36'h9_ABCD_1234, 1'b0, k);
    idle();
    repeat (5) @(negedge clk);

    // Preload, then read / write / read back-to-back
    send(1'b1, 19'h1, 36'h1_1111_0001, 1'b0, k);
    send(1'b1, 19'h3, 36'h3_3333_0003, 1'b0, k);
    idle();
    repeat (5) @(negedge clk);
    send(1'b0, 19'h1, 36'h0, 1'b0, k);
    send(1'b1, 19'h2, 36'h2_2222_0002, 1'b0, k);
    send(1'b0, 19'h3, 36'h0, 1'b0, k);
    send(1'b0, 19'h2, 36'h0, 1'b0, k);
    // Write followed immediately by a read of the same word
    send(1'b1, 19'h5, 36'hF_0F0F_5555, 1'b0, k);
    send(1'b0, 19'h5, 36'h0, 1'b0, k);
    idle();
    repeat (6) @(negedge clk);

    // Lock lost during a 10-request burst
    send(1'b1, 19'h8, 36'h8_0000_0008, 1'b0, k0);
    send(1'b0, 19'h8, 36'h0, 1'b0, k);
    send(1'b1, 19'h9, 36'h9_0000_0009, 1'b1, k2);
    #1;
    chk("ready_after_unlock", 64'(req_ready), 64'(0));
    chk("burst_b2b", 64'(k2), 64'(k0 + 2));
    fork
      begin
        for (int i = 3; i < 10; i++) begin
          send(i[0], AW'(8 + (i % 4)), {4'(i), 32'hA5A5_0000 + 32'(i)}, 1'b0, k);
          if (i == 3) k3 = k;
        end
      end
      begin
        repeat (5) @(negedge clk);
        r0 = cyc;
        clk_locked = 1'b1;
        check_settle("relock");
      end
    join
    chk("first_after_relock", 64'(k3), 64'(r0 + ST + 2));
    idle();
    repeat (6) @(negedge clk);

    // Reset one cycle after a read accept
    send(1'b0, 19'h1, 36'h0, 1'b0, k);
    idle();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("async_reset");
    cmd_q.delete();
    wr_q.delete();
    rd_q.delete();
    last_addr = '0;
    last_rd   = '0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    check_settle("post_reset");

    // Random traffic
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      send(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
           {4'($urandom), $urandom}, 1'b0, k);
    end
    idle();
    repeat (8) @(negedge clk);
    chk("drained", 64'(cmd_q.size() + wr_q.size() + rd_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
